// File: rtl/program_counter_if.sv
// Harness <-> fetch-stage PC bus: run control and branch inputs in, PC/status/count out.
interface program_counter_if #(
    parameter int D     = 12,
    parameter int CNT_W = 16
);
    logic             start;
    logic             stall;
    logic             halt;
    logic             branch_en;
    logic             rel;
    logic [D-1:0]     target;
    logic [D-1:0]     prog_ctr;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] inst_count;

    modport master (
        output start, stall, halt, branch_en, rel, target,
        input  prog_ctr, running, done, inst_count
    );

    modport slave (
        input  start, stall, halt, branch_en, rel, target,
        output prog_ctr, running, done, inst_count
    );
endinterface

// File: rtl/program_counter.sv
// Fetch-stage program counter with IDLE/RUN/DONE run control and a saturating
// retired-instruction counter.
module program_counter #(
    parameter int           D          = 12,
    parameter logic [D-1:0] START_ADDR = '0,
    parameter int           CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    program_counter_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [D-1:0]     r_pc;
    logic [D-1:0]     w_pc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_adv;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.start)
            w_next = S_RUN;
        else if (r_state == S_RUN && !bus.stall && bus.halt)
            w_next = S_DONE;
    end

    always_comb begin
        bus.running = (r_state == S_RUN);
        bus.done    = (r_state == S_DONE);
    end

    // An unstalled RUN cycle retires one instruction, halt included.
    assign w_adv = (r_state == S_RUN) && !bus.start && !bus.stall;

    always_comb begin
        w_pc_nxt = r_pc;
        if (bus.start)
            w_pc_nxt = START_ADDR;
        else if (w_adv && !bus.halt) begin
            if (bus.branch_en)
                w_pc_nxt = bus.rel ? (r_pc + bus.target) : bus.target;
            else
                w_pc_nxt = r_pc + D'(1);
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bus.start)
            w_cnt_nxt = '0;
        else if (w_adv && (r_cnt != {CNT_W{1'b1}}))
            w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc  <= '0;
            r_cnt <= '0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign bus.prog_ctr   = r_pc;
    assign bus.inst_count = r_cnt;

endmodule
